iir_hpf_ctrl: RTL and testbench
===============================

IIR_HPF_CTRL -- requirements
Module: iir_hpf_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1024, max cycles per filter-side wait phase.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have ports input_a / input_a_stb / input_a_ack  in/in/out  32/1/1  source float sample stream.
REQ-006 SHALL have ports o_X_DATA / o_X_DATA_VALID / i_X_DATA_READY  out/out/in  32/1/1  filter input side.
REQ-007 SHALL have ports i_Y_DATA / i_Y_DATA_VALID / o_Y_ACK  in/in/out  32/1/1  filter output side.
REQ-008 SHALL have ports output_z / output_z_stb / output_z_ack  out/out/in  32/1/1  sink float stream.
REQ-009 SHALL have port o_TIMEOUT  output  1  sticky watchdog error flag.
REQ-010 SHALL have port o_SAMPLE_CNT  output  16  count of samples written to output FIFO, wraps 0xFFFF->0.

Function
REQ-011 SHALL treat every stream as stb/ack (or valid/ready): a transfer occurs in a cycle where both are high; producer holds data and strobe stable until the transfer.
REQ-012 SHALL implement FSM IDLE -> ACCEPT -> SEND_X -> WAIT_Y -> IDLE, with exactly one sample in flight in the filter at any time.
REQ-013 IDLE: if input_a_stb=1 and FIFO count < FIFO_DEPTH, SHALL register input_a_ack=1 for the next cycle and go to ACCEPT; otherwise input_a_ack=0.
REQ-014 ACCEPT: SHALL latch input_a into the sample register, drop input_a_ack, and go to SEND_X (input_a_ack is high for exactly one cycle per sample).
REQ-015 SEND_X: SHALL drive o_X_DATA_VALID=1 with the latched sample; on i_X_DATA_READY=1, SHALL drop valid next cycle and go to WAIT_Y.
REQ-016 WAIT_Y: on i_Y_DATA_VALID=1, SHALL assert o_Y_ACK for one cycle, push i_Y_DATA into the FIFO, increment o_SAMPLE_CNT, and return to IDLE.
REQ-017 FIFO SHALL be first-word-fall-through: output_z_stb = not empty, output_z = head entry; pop on output_z_stb and output_z_ack.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; the FIFO never overflows because admission in REQ-013 reserves the slot.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-020 Watchdog counter SHALL clear on entry to SEND_X and WAIT_Y, increment each cycle in those states, and on reaching TIMEOUT-1 SHALL set o_TIMEOUT, discard the sample (no push, no count), deassert filter-side handshakes, and go to IDLE.
REQ-021 o_TIMEOUT SHALL stay set until reset; processing SHALL continue after a timeout.
REQ-022 Minimum input-to-FIFO latency SHALL be 4 cycles plus filter latency, with ready and valid returned immediately.

Reset
REQ-023 On rst=1 at a clock edge, SHALL enter IDLE, empty the FIFO, and clear the watchdog; input_a_ack, o_X_DATA_VALID, o_Y_ACK, output_z_stb, and o_TIMEOUT SHALL be 0, and o_SAMPLE_CNT, o_X_DATA, and output_z SHALL be 0.
REQ-024 Reset mid-operation SHALL discard any in-flight sample and all FIFO contents without emitting them.

Configuration
REQ-025 With macro IIR_HPF_CTRL_BYPASS_EN defined, SHALL add port i_BYPASS (input, 1); when i_BYPASS=1 in ACCEPT, SHALL push the sample directly into the FIFO, incrementing o_SAMPLE_CNT and skipping SEND_X and WAIT_Y.
REQ-026 i_BYPASS SHALL be sampled only in ACCEPT, so a change mid-sample has no effect on that sample.
REQ-027 Without IIR_HPF_CTRL_BYPASS_EN, i_BYPASS SHALL not exist and every sample SHALL pass through the filter.

Verification
REQ-028 Single sample: input_a=0x3F800000, filter returns 0x3F000000 after 5 cycles, sink ack=1 -> output_z=0x3F000000 once, o_SAMPLE_CNT=1.
REQ-029 Back-pressure: sink ack=0, 6 samples offered -> exactly 4 accepted, input_a_ack stays 0 afterwards; releasing the sink delivers 4 then 2 more, in order.
REQ-030 Watchdog: TIMEOUT=16, filter never asserts i_Y_DATA_VALID -> o_TIMEOUT=1 after 16 WAIT_Y cycles, no output; the next sample is processed normally.
REQ-031 Simultaneous push and pop with FIFO at 3 entries -> count stays 3, order preserved.
REQ-032 Reset asserted in WAIT_Y with 2 FIFO entries -> all outputs 0 next cycle; the late i_Y_DATA_VALID is not acked.
REQ-033 Bypass build with i_BYPASS=1: input 0x40000000 -> output_z=0x40000000, o_X_DATA_VALID never asserted.

Source files
------------

// File: rtl/iir_hpf_ctrl.sv
// rtl/iir_hpf_ctrl.sv - sequencer between a float sample stream, an external IIR high-pass filter and a FWFT output FIFO
// Optional feature macro: IIR_HPF_CTRL_BYPASS_EN adds i_BYPASS to route samples straight to the FIFO.
module iir_hpf_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IIR_HPF_CTRL_BYPASS_EN
    input  logic        i_BYPASS,
`endif
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] o_X_DATA,
    output logic        o_X_DATA_VALID,
    input  logic        i_X_DATA_READY,
    input  logic [31:0] i_Y_DATA,
    input  logic        i_Y_DATA_VALID,
    output logic        o_Y_ACK,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack,
    output logic        o_TIMEOUT,
    output logic [15:0] o_SAMPLE_CNT
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND_X = 2'd2,
        WAIT_Y = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    sample_q, sample_d;
    logic           a_ack_q, a_ack_d;
    logic           xv_q, xv_d;
    logic           yack_q, yack_d;
    logic [WW-1:0]  wd_q, wd_d;
    logic           to_q, to_d;
    logic [15:0]    cnt_q, cnt_d;

    logic           push;
    logic [31:0]    push_data;
    logic           pop;

    logic [31:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  fcnt_q;

    // Admission reserves a FIFO slot, so a sample in flight can always be pushed.
    logic           slot_free;
    logic           wd_expired;
    assign slot_free  = fcnt_q < CW'(FIFO_DEPTH);
    assign wd_expired = (wd_q == WW'(TIMEOUT - 1));
    assign pop        = (fcnt_q != '0) && output_z_ack;

    // Next-state and handshake decisions; all handshake outputs are registered.
    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        a_ack_d   = 1'b0;
        xv_d      = 1'b0;
        yack_d    = 1'b0;
        wd_d      = wd_q;
        to_d      = to_q;
        push      = 1'b0;
        push_data = i_Y_DATA;
        case (state_q)
            IDLE: begin
                if (input_a_stb && slot_free) begin
                    a_ack_d = 1'b1;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                sample_d = input_a;
                wd_d     = '0;
`ifdef IIR_HPF_CTRL_BYPASS_EN
                if (i_BYPASS) begin
                    push      = 1'b1;
                    push_data = input_a;
                    state_d   = IDLE;
                end else begin
                    xv_d    = 1'b1;
                    state_d = SEND_X;
                end
`else
                xv_d    = 1'b1;
                state_d = SEND_X;
`endif
            end
            SEND_X: begin
                if (i_X_DATA_READY) begin
                    wd_d    = '0;
                    state_d = WAIT_Y;
                end else if (wd_expired) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    xv_d = 1'b1;
                    wd_d = wd_q + WW'(1);
                end
            end
            WAIT_Y: begin
                if (i_Y_DATA_VALID) begin
                    yack_d  = 1'b1;
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    // Sample is dropped: nothing pushed, nothing counted.
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q + 16'(push);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sample_q <= '0;
            a_ack_q  <= 1'b0;
            xv_q     <= 1'b0;
            yack_q   <= 1'b0;
            wd_q     <= '0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            a_ack_q  <= a_ack_d;
            xv_q     <= xv_d;
            yack_q   <= yack_d;
            wd_q     <= wd_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + CW'(1);
                2'b01:   fcnt_q <= fcnt_q - CW'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    assign input_a_ack    = a_ack_q;
    assign o_X_DATA       = sample_q;
    assign o_X_DATA_VALID = xv_q;
    assign o_Y_ACK        = yack_q;
    assign output_z_stb   = (fcnt_q != '0);
    assign output_z       = (fcnt_q != '0) ? mem_q[rd_q] : 32'h0;
    assign o_TIMEOUT      = to_q;
    assign o_SAMPLE_CNT   = cnt_q;

endmodule

// File: tb/tb_iir_hpf_ctrl.sv
// tb/tb_iir_hpf_ctrl.sv - directed self-checking bench for iir_hpf_ctrl
module tb_iir_hpf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] o_X_DATA;
    logic        o_X_DATA_VALID;
    logic        i_X_DATA_READY;
    logic [31:0] i_Y_DATA;
    logic        i_Y_DATA_VALID;
    logic        o_Y_ACK;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    logic        o_TIMEOUT;
    logic [15:0] o_SAMPLE_CNT;
`ifdef IIR_HPF_CTRL_BYPASS_EN
    logic        i_BYPASS;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt;
    bit ok;
    bit xv_seen;

    always #5 clk = ~clk;

    iir_hpf_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef IIR_HPF_CTRL_BYPASS_EN
        .i_BYPASS       (i_BYPASS),
`endif
        .input_a        (input_a),
        .input_a_stb    (input_a_stb),
        .input_a_ack    (input_a_ack),
        .o_X_DATA       (o_X_DATA),
        .o_X_DATA_VALID (o_X_DATA_VALID),
        .i_X_DATA_READY (i_X_DATA_READY),
        .i_Y_DATA       (i_Y_DATA),
        .i_Y_DATA_VALID (i_Y_DATA_VALID),
        .o_Y_ACK        (o_Y_ACK),
        .output_z       (output_z),
        .output_z_stb   (output_z_stb),
        .output_z_ack   (output_z_ack),
        .o_TIMEOUT      (o_TIMEOUT),
        .o_SAMPLE_CNT   (o_SAMPLE_CNT)
    );

    always @(negedge clk) if (o_X_DATA_VALID) xv_seen = 1'b1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] y;
        int          dly;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] d, input int max, output bit acc);
        input_a     = d;
        input_a_stb = 1'b1;
        acc         = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (input_a_ack) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
    endtask

    task automatic filter_serve(input logic [31:0] exp_x, input logic [31:0] y, input int dly,
                                input bit pop, input logic [31:0] exp_head);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_X_DATA_VALID) begin
                seen = 1'b1;
                break;
            end
        end
        chk("x_valid_seen", 32'(seen), 32'd1);
        chk("x_data", o_X_DATA, exp_x);
        i_X_DATA_READY = 1'b1;
        @(posedge clk);
        #1;
        i_X_DATA_READY = 1'b0;
        repeat (dly) @(posedge clk);
        #1;
        i_Y_DATA       = y;
        i_Y_DATA_VALID = 1'b1;
        if (pop) begin
            output_z_ack = 1'b1;
            @(negedge clk);
            chk("head_at_push", output_z, exp_head);
            @(posedge clk);
            #1;
            output_z_ack = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_Y_ACK) begin
                seen = 1'b1;
                break;
            end
        end
        chk("y_ack_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        i_Y_DATA_VALID = 1'b0;
        @(negedge clk);
        chk("y_ack_one_cycle", 32'(o_Y_ACK), 32'd0);
    endtask

    task automatic get_z(input string name, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (output_z_stb) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_stb"}, 32'(seen), 32'd1);
        chk(name, output_z, exp);
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
    endtask

    task automatic do_sample(input logic [31:0] a, input logic [31:0] y, input int dly);
        send_a(a, 20, ok);
        chk("accept", 32'(ok), 32'd1);
        filter_serve(a, y, dly, 1'b0, 32'h0);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        vecs[0] = '{a: 32'h3F800000, y: 32'h3F000000, dly: 5, cnt: 16'd1};
        vecs[1] = '{a: 32'h40000000, y: 32'hC0000000, dly: 0, cnt: 16'd2};
        vecs[2] = '{a: 32'hFFFFFFFF, y: 32'h00000001, dly: 2, cnt: 16'd3};
        vecs[3] = '{a: 32'h00000000, y: 32'h12345678, dly: 1, cnt: 16'd4};

        rst            = 1'b1;
        input_a        = 32'h0;
        input_a_stb    = 1'b0;
        i_X_DATA_READY = 1'b0;
        i_Y_DATA       = 32'h0;
        i_Y_DATA_VALID = 1'b0;
        output_z_ack   = 1'b0;
        exp_cnt        = 16'd0;
`ifdef IIR_HPF_CTRL_BYPASS_EN
        i_BYPASS       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_ack", 32'(input_a_ack), 32'd0);
        chk("rst_x_valid", 32'(o_X_DATA_VALID), 32'd0);
        chk("rst_y_ack", 32'(o_Y_ACK), 32'd0);
        chk("rst_z_stb", 32'(output_z_stb), 32'd0);
        chk("rst_timeout", 32'(o_TIMEOUT), 32'd0);
        chk("rst_cnt", 32'(o_SAMPLE_CNT), 32'd0);
        chk("rst_x_data", o_X_DATA, 32'd0);
        chk("rst_z", output_z, 32'd0);

        // Table: one sample at a time through the filter, drained immediately.
        for (int i = 0; i < 4; i++) begin
            send_a(vecs[i].a, 20, ok);
            chk("vec_accept", 32'(ok), 32'd1);
            @(negedge clk);
            chk("vec_ack_one_cycle", 32'(input_a_ack), 32'd0);
            filter_serve(vecs[i].a, vecs[i].y, vecs[i].dly, 1'b0, 32'h0);
            get_z("vec_z", vecs[i].y);
            chk("vec_cnt", 32'(o_SAMPLE_CNT), 32'(vecs[i].cnt));
            @(negedge clk);
            chk("vec_z_single", 32'(output_z_stb), 32'd0);
        end
        exp_cnt = 16'd4;

        // Back-pressure: sink stalled, only four samples admitted.
        for (int i = 0; i < 4; i++) do_sample(32'h100 + 32'(i), 32'hA00 + 32'(i), 1);
        send_a(32'h104, 30, ok);
        chk("bp_fifth_refused", 32'(ok), 32'd0);
        chk("bp_no_x_valid", 32'(o_X_DATA_VALID), 32'd0);
        for (int i = 0; i < 4; i++) get_z("bp_order", 32'hA00 + 32'(i));
        do_sample(32'h104, 32'hA04, 0);
        do_sample(32'h105, 32'hA05, 3);
        get_z("bp_late4", 32'hA04);
        get_z("bp_late5", 32'hA05);
        chk("bp_cnt", 32'(o_SAMPLE_CNT), 32'(exp_cnt));

        // Push and pop in the same cycle with three entries held.
        for (int i = 0; i < 3; i++) do_sample(32'h200 + 32'(i), 32'hB00 + 32'(i), 0);
        send_a(32'h203, 20, ok);
        chk("pp_accept", 32'(ok), 32'd1);
        filter_serve(32'h203, 32'hB03, 0, 1'b1, 32'hB00);
        exp_cnt = exp_cnt + 16'd1;
        for (int i = 1; i < 4; i++) get_z("pp_order", 32'hB00 + 32'(i));
        @(negedge clk);
        chk("pp_empty_after3", 32'(output_z_stb), 32'd0);
        chk("pp_cnt", 32'(o_SAMPLE_CNT), 32'(exp_cnt));

        // Watchdog: filter takes the sample but never answers.
        send_a(32'h300, 20, ok);
        chk("wd_accept", 32'(ok), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_X_DATA_VALID) break;
        end
        i_X_DATA_READY = 1'b1;
        @(posedge clk);
        #1;
        i_X_DATA_READY = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("wd_not_yet", 32'(o_TIMEOUT), 32'd0);
        @(negedge clk);
        chk("wd_timeout", 32'(o_TIMEOUT), 32'd1);
        chk("wd_no_output", 32'(output_z_stb), 32'd0);
        chk("wd_cnt", 32'(o_SAMPLE_CNT), 32'(exp_cnt));
        do_sample(32'h301, 32'hC01, 2);
        get_z("wd_next", 32'hC01);
        chk("wd_sticky", 32'(o_TIMEOUT), 32'd1);

        // Reset while waiting on the filter with two entries queued.
        do_sample(32'h400, 32'hD00, 0);
        do_sample(32'h401, 32'hD01, 0);
        send_a(32'h402, 20, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_X_DATA_VALID) break;
        end
        i_X_DATA_READY = 1'b1;
        @(posedge clk);
        #1;
        i_X_DATA_READY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_z_stb", 32'(output_z_stb), 32'd0);
        chk("mid_rst_z", output_z, 32'd0);
        chk("mid_rst_cnt", 32'(o_SAMPLE_CNT), 32'd0);
        chk("mid_rst_timeout", 32'(o_TIMEOUT), 32'd0);
        chk("mid_rst_x_valid", 32'(o_X_DATA_VALID), 32'd0);
        i_Y_DATA       = 32'hDEAD;
        i_Y_DATA_VALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_Y_ACK || output_z_stb) ok = 1'b1;
        end
        chk("late_y_ignored", 32'(ok), 32'd0);
        @(posedge clk);
        #1;
        i_Y_DATA_VALID = 1'b0;

`ifdef IIR_HPF_CTRL_BYPASS_EN
        // Bypass: sample goes straight to the FIFO.
        xv_seen  = 1'b0;
        i_BYPASS = 1'b1;
        send_a(32'h40000000, 20, ok);
        chk("byp_accept", 32'(ok), 32'd1);
        get_z("byp_z", 32'h40000000);
        chk("byp_no_x_valid", 32'(xv_seen), 32'd0);
        chk("byp_cnt", 32'(o_SAMPLE_CNT), 32'd1);
        i_BYPASS = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
